// File: rtl/sd_read_scheduler.sv
// sd_read_scheduler
//   Shares one single-block SD read engine between two requesters. Each
//   requester asks for a run of consecutive blocks; grants are round-robin,
//   one block command is issued at a time once the downstream FIFO is empty
//   and the engine is idle. Failed or timed-out blocks are retried up to
//   MAX_RETRY times before the request is aborted.
//
// Ports
//   SCLK, reset_n         clock (posedge) and asynchronous active-low reset
//   req0/1                request, held until the matching done pulse
//   addr0/1, nblk0/1      start byte address and block count, taken at grant
//   gnt0/1                high from grant through the done cycle
//   done0/1, err0/1       one-cycle completion pulse; err=1 means aborted
//   blk_start, blk_addr   one-cycle engine start and the block byte address
//   blk_busy, blk_ok,     engine status and one-cycle result pulses
//   blk_fail
//   fifo_empty            downstream FIFO empty, gates every block start
//   busy                  scheduler not idle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transfer; waits for any request
// ARB       | picks requester, latches address/count, asserts its gnt
// WAIT_FIFO | waits for FIFO empty and engine idle
// ISSUE     | pulses blk_start, loads the response timer
// WAIT_BLK  | waits for blk_ok / blk_fail / timer expiry
// NEXT      | advances address, decrements remaining count
// FINISH    | done pulse to the owner, err = abort flag
module sd_read_scheduler #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [15:0] TIMEOUT     = 16'd20000
) (
    input  logic        SCLK,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [7:0]  nblk0,
    input  logic [7:0]  nblk1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        blk_start,
    output logic [31:0] blk_addr,
    input  logic        blk_busy,
    input  logic        blk_ok,
    input  logic        blk_fail,
    input  logic        fifo_empty,
    output logic        busy
);

    localparam int unsigned RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1);
    localparam logic [31:0] ADDR_STEP = 32'(BLOCK_BYTES);
    // Down-counter load: expiry on the TIMEOUT-th cycle spent in WAIT_BLK.
    localparam logic [15:0] TMO_LOAD  = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        WAIT_FIFO = 3'd2,
        ISSUE     = 3'd3,
        WAIT_BLK  = 3'd4,
        NEXT      = 3'd5,
        FINISH    = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;       // 0: requester 0 has priority
    logic          owner_q, owner_d;   // requester currently granted
    logic [31:0]   cur_addr_q, cur_addr_d;
    logic [31:0]   blk_addr_q, blk_addr_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          abort_q, abort_d;

    logic          any_req;
    logic          grant_sel;
    logic [31:0]   sel_addr;
    logic [7:0]    sel_nblk;
    logic          in_xfer;

    assign any_req   = req0 | req1;
    assign grant_sel = ptr_q ? req1 : ~req0;
    assign sel_addr  = grant_sel ? addr1 : addr0;
    assign sel_nblk  = grant_sel ? nblk1 : nblk0;

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cur_addr_q  <= '0;
            blk_addr_q  <= '0;
            remaining_q <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cur_addr_q  <= cur_addr_d;
            blk_addr_q  <= blk_addr_d;
            remaining_q <= remaining_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cur_addr_d  = cur_addr_q;
        blk_addr_d  = blk_addr_q;
        remaining_d = remaining_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        abort_d     = abort_q;

        case (state_q)
            IDLE: begin
                if (any_req) state_d = ARB;
            end
            ARB: begin
                if (any_req) begin
                    owner_d     = grant_sel;
                    ptr_d       = ~grant_sel;
                    cur_addr_d  = sel_addr;
                    remaining_d = sel_nblk;
                    retry_d     = '0;
                    abort_d     = 1'b0;
                    state_d     = (sel_nblk == 8'd0) ? FINISH : WAIT_FIFO;
                end else begin
                    // request vanished between IDLE and ARB: nothing to grant
                    state_d = IDLE;
                end
            end
            WAIT_FIFO: begin
                if (fifo_empty && !blk_busy) begin
                    blk_addr_d = cur_addr_q;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = TMO_LOAD;
                state_d = WAIT_BLK;
            end
            WAIT_BLK: begin
                if (blk_ok) begin
                    state_d = NEXT;
                end else if (blk_fail || (tmo_q == 16'd0)) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RETRY_ONE;
                        state_d = WAIT_FIFO;
                    end else begin
                        abort_d = 1'b1;
                        state_d = FINISH;
                    end
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            NEXT: begin
                cur_addr_d  = cur_addr_q + ADDR_STEP;
                remaining_d = remaining_q - 8'd1;
                retry_d     = '0;
                state_d     = (remaining_q == 8'd1) ? FINISH : WAIT_FIFO;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_xfer = (state_q == WAIT_FIFO) || (state_q == ISSUE) ||
                     (state_q == WAIT_BLK)  || (state_q == NEXT)  ||
                     (state_q == FINISH);

    // In ARB the grant is shown combinationally so gnt rises with the grant.
    assign gnt0      = (state_q == ARB) ? (any_req & ~grant_sel) : (in_xfer & ~owner_q);
    assign gnt1      = (state_q == ARB) ? (any_req &  grant_sel) : (in_xfer &  owner_q);
    assign done0     = (state_q == FINISH) & ~owner_q;
    assign done1     = (state_q == FINISH) &  owner_q;
    assign err0      = done0 & abort_q;
    assign err1      = done1 & abort_q;
    assign blk_start = (state_q == ISSUE);
    assign blk_addr  = blk_addr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sd_read_scheduler.sv
module tb_sd_read_scheduler;

    localparam logic [15:0] TB_TIMEOUT = 16'd200;
    localparam int          TB_RETRY   = 3;

    logic        SCLK;
    logic        reset_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [7:0]  nblk0, nblk1;
    logic        gnt0, gnt1, done0, done1, err0, err1, blk_start;
    logic [31:0] blk_addr;
    logic        blk_busy, blk_ok, blk_fail, fifo_empty;
    logic        busy;

    sd_read_scheduler #(
        .BLOCK_BYTES(512),
        .MAX_RETRY  (TB_RETRY),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .SCLK      (SCLK),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .nblk0     (nblk0),
        .nblk1     (nblk1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .blk_start (blk_start),
        .blk_addr  (blk_addr),
        .blk_busy  (blk_busy),
        .blk_ok    (blk_ok),
        .blk_fail  (blk_fail),
        .fifo_empty(fifo_empty),
        .busy      (busy)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] exp_addr_q[$];
    logic [1:0]  exp_done_q[$];   // {who, err}

    int          cyc = 0;
    int          n_starts = 0;
    int          n_dones = 0;
    int          last_ok_cyc = 0;
    int          last_start_cyc = 0;
    int          last_gap = 0;
    int          last_ss = 0;
    logic [31:0] last_start_addr = '0;
    int          gnt1_cnt = 0;
    int          gnt_overlap = 0;

    int          eng_lat = 50;
    int          eng_fail_left = 0;
    logic [31:0] eng_fail_addr = '0;
    bit          eng_silent = 0;
    int          eng_cnt = 0;

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    initial forever begin
        @(posedge SCLK);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_done(input logic who, input logic err);
        exp_done_q.push_back({who, err});
    endtask

    // Engine model: answers each start after eng_lat cycles, with blk_fail
    // while eng_fail_left>0 at eng_fail_addr, or never when eng_silent.
    initial begin
        blk_ok = 1'b0; blk_fail = 1'b0; blk_busy = 1'b0;
        forever begin
            @(posedge SCLK);
            #1;
            blk_ok = 1'b0;
            blk_fail = 1'b0;
            if (!reset_n) begin
                eng_cnt = 0;
            end else if (blk_start) begin
                if (!eng_silent) eng_cnt = eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    if (eng_fail_left > 0 && blk_addr == eng_fail_addr) begin
                        blk_fail = 1'b1;
                        eng_fail_left--;
                    end else begin
                        blk_ok = 1'b1;
                    end
                end
            end
            blk_busy = (eng_cnt > 0);
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge SCLK);
        if (reset_n) begin
            if (gnt0 && gnt1) gnt_overlap++;
            if (gnt1) gnt1_cnt++;
            if (blk_ok || blk_fail) check("addr_stable", blk_addr, last_start_addr);
            if (blk_ok) last_ok_cyc = cyc;
            if (blk_start) begin
                check("start_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) check("blk_addr", blk_addr, exp_addr_q.pop_front());
                n_starts++;
                last_gap = cyc - last_ok_cyc;
                last_ss = cyc - last_start_cyc;
                last_start_cyc = cyc;
                last_start_addr = blk_addr;
            end
            if (done0 || done1) begin
                logic [1:0] e;
                n_dones++;
                check("done_expected", 32'(exp_done_q.size() > 0), 32'd1);
                if (exp_done_q.size() > 0) begin
                    e = exp_done_q.pop_front();
                    check("done_err", 32'({done1, done0, err1, err0}),
                          32'({e[1], ~e[1], e[1] & e[0], ~e[1] & e[0]}));
                end
            end
        end
    end

    task automatic wait_done(input logic who, input int budget, input bit drop);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge SCLK);
            if ((!who && done0) || (who && done1)) got = 1;
        end
        check("done_in_budget", 32'(got), 32'd1);
        if (drop) begin
            if (who) req1 = 1'b0;
            else req0 = 1'b0;
        end
    endtask

    task automatic wait_start(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge SCLK);
            if (blk_start) got = 1;
        end
        check("start_in_budget", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge SCLK);
        reset_n = 1'b0;
        repeat (2) @(negedge SCLK);
        reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int d;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        nblk0 = '0; nblk1 = '0;
        fifo_empty = 1'b1;

        repeat (2) @(negedge SCLK);
        check("reset_outs", 32'({gnt0, gnt1, done0, done1, err0, err1, blk_start, busy}), 32'd0);
        check("reset_addr", blk_addr, 32'd0);
        reset_n = 1'b1;

        // Single request, three blocks.
        gnt1_cnt = 0;
        addr0 = 32'h0000_0000; nblk0 = 8'd3; req0 = 1'b1;
        exp_addr_q.push_back(32'h000);
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h400);
        push_done(1'b0, 1'b0);
        @(negedge SCLK);
        check("arb_grant", 32'({gnt0, gnt1, blk_start, busy}), 32'b1001);
        @(negedge SCLK);
        @(negedge SCLK);
        check("grant_to_start", 32'(blk_start), 32'd1);
        wait_done(1'b0, 1000, 1'b1);
        check("gnt1_idle", 32'(gnt1_cnt), 32'd0);
        check("ok_to_start_gap", 32'(last_gap), 32'd3);

        // Contention after reset: 0 then 1, then both held: 0,1,0,1.
        do_reset();
        addr0 = 32'h1000; nblk0 = 8'd1;
        addr1 = 32'h8000; nblk1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        exp_addr_q.push_back(32'h1000); push_done(1'b0, 1'b0);
        exp_addr_q.push_back(32'h8000); push_done(1'b1, 1'b0);
        wait_done(1'b0, 300, 1'b1);
        wait_done(1'b1, 300, 1'b1);
        @(negedge SCLK);
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_addr_q.push_back((k % 2 == 0) ? 32'h1000 : 32'h8000);
            push_done(1'((k % 2) != 0), 1'b0);
        end
        wait_done(1'b0, 300, 1'b0);
        wait_done(1'b1, 300, 1'b0);
        wait_done(1'b0, 300, 1'b0);
        wait_done(1'b1, 300, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        check("gnt_exclusive", 32'(gnt_overlap), 32'd0);

        // Retry: two failures at 0x200, then success.
        @(negedge SCLK);
        s = n_starts;
        eng_fail_addr = 32'h200; eng_fail_left = 2;
        addr0 = 32'h0; nblk0 = 8'd2; req0 = 1'b1;
        exp_addr_q.push_back(32'h000);
        repeat (3) exp_addr_q.push_back(32'h200);
        push_done(1'b0, 1'b0);
        wait_done(1'b0, 1000, 1'b1);
        check("retry_starts", 32'(n_starts - s), 32'd4);

        // Abort on persistent failure.
        @(negedge SCLK);
        s = n_starts;
        eng_fail_addr = 32'h3000; eng_fail_left = 100;
        addr1 = 32'h3000; nblk1 = 8'd2; req1 = 1'b1;
        repeat (1 + TB_RETRY) exp_addr_q.push_back(32'h3000);
        push_done(1'b1, 1'b1);
        wait_done(1'b1, 1000, 1'b1);
        check("abort_starts", 32'(n_starts - s), 32'(1 + TB_RETRY));
        eng_fail_left = 0;

        // Abort on timeout.
        @(negedge SCLK);
        s = n_starts;
        eng_silent = 1;
        addr0 = 32'h4000; nblk0 = 8'd1; req0 = 1'b1;
        repeat (1 + TB_RETRY) exp_addr_q.push_back(32'h4000);
        push_done(1'b0, 1'b1);
        wait_done(1'b0, 2000, 1'b1);
        check("timeout_starts", 32'(n_starts - s), 32'(1 + TB_RETRY));
        check("timeout_spacing", 32'(last_ss), 32'(TB_TIMEOUT) + 32'd2);
        eng_silent = 0;

        // FIFO gating between blocks.
        @(negedge SCLK);
        addr0 = 32'h6000; nblk0 = 8'd2; req0 = 1'b1;
        exp_addr_q.push_back(32'h6000);
        exp_addr_q.push_back(32'h6200);
        push_done(1'b0, 1'b0);
        wait_start(100);
        @(negedge SCLK);
        s = n_starts;
        fifo_empty = 1'b0;
        repeat (100) @(negedge SCLK);
        check("fifo_gate", 32'(n_starts - s), 32'd0);
        fifo_empty = 1'b1;
        @(negedge SCLK);
        check("fifo_release", 32'(blk_start), 32'd1);
        wait_done(1'b0, 300, 1'b1);

        // Zero-length request.
        @(negedge SCLK);
        s = n_starts;
        addr1 = 32'h5000; nblk1 = 8'd0; req1 = 1'b1;
        push_done(1'b1, 1'b0);
        @(negedge SCLK);
        check("nblk0_arb", 32'({gnt1, done1}), 32'b10);
        @(negedge SCLK);
        check("nblk0_done", 32'({gnt1, done1, err1}), 32'b110);
        req1 = 1'b0;
        @(negedge SCLK);
        check("nblk0_no_start", 32'(n_starts - s), 32'd0);

        // Address wrap.
        addr0 = 32'hFFFF_FE00; nblk0 = 8'd2; req0 = 1'b1;
        exp_addr_q.push_back(32'hFFFF_FE00);
        exp_addr_q.push_back(32'h0000_0000);
        push_done(1'b0, 1'b0);
        wait_done(1'b0, 300, 1'b1);

        // Asynchronous reset while waiting on a block.
        @(negedge SCLK);
        eng_silent = 1;
        addr0 = 32'h7000; nblk0 = 8'd1; req0 = 1'b1;
        exp_addr_q.push_back(32'h7000);
        wait_start(20);
        repeat (5) @(negedge SCLK);
        d = n_dones;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({gnt0, gnt1, done0, done1, err0, err1, blk_start, busy}), 32'd0);
        check("async_rst_addr", blk_addr, 32'd0);
        req0 = 1'b0;
        repeat (3) @(negedge SCLK);
        reset_n = 1'b1;
        eng_silent = 0;
        repeat (20) @(negedge SCLK);
        check("async_rst_no_done", 32'(n_dones - d), 32'd0);
        check("async_rst_idle", 32'(busy), 32'd0);

        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
